// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/DMA single-port RAM arbiter.
package mem_arb_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, DMA and RAM-side signals of the arbiter; slave is the arbiter view,
// master is the surrounding datapath/RAM view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
);

  logic          CPU_REQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_STALL;
  logic          CPU_RVALID;

  logic          DMA_REQ;
  logic          DMA_WE;
  logic [AW-1:0] DMA_ADDR;
  logic [DW-1:0] DMA_WDATA;
  logic          DMA_LAST;
  logic          DMA_GNT;
  logic          DMA_RVALID;

  logic          RAM_EN;
  logic          RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_WDATA;

  logic [1:0]    OWNER;

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_LAST,
    output CPU_STALL, CPU_RVALID, DMA_GNT, DMA_RVALID,
    output RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA, OWNER
  );

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_LAST,
    input  CPU_STALL, CPU_RVALID, DMA_GNT, DMA_RVALID,
    input  RAM_EN, RAM_WE, RAM_ADDR, RAM_WDATA, OWNER
  );

endinterface

// File: rtl/mem_arb_mux.sv
// Combinational RAM port selector; zero latency, CPU select takes precedence.
// No backpressure of its own: idle port drives all-zero with RAM_EN low.
module mem_arb_mux #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_sel,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata
);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_sel) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_sel) begin
      ram_en    = 1'b1;
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU-priority RAM arbiter with DMA starvation guard and burst cap.
// CPU served same cycle; DMA beats start one cycle after winning; losers see STALL / no GNT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = MEM_AW,
  parameter int DW        = MEM_DW,
  parameter int BURST_MAX = 8,
  parameter int WAIT_MAX  = 4
) (
  input logic          CLK,
  input logic          RESET_N,
  mem_arbiter_if.slave bus
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP = WW'(WAIT_MAX);
  localparam logic [BW-1:0] BEAT_TOP = BW'(BURST_MAX - 1);

  owner_t        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          cpu_rvalid_q, dma_rvalid_q;
  logic          cpu_serve, dma_serve, dma_gnt;
  logic          cpu_sel, dma_sel;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      cpu_rvalid_q <= cpu_serve & ~bus.CPU_WE;
      dma_rvalid_q <= dma_serve & ~bus.DMA_WE;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    cpu_serve  = 1'b0;
    dma_serve  = 1'b0;
    dma_gnt    = 1'b0;

    case (state_q)
      DMA_OWN: begin
        dma_gnt = 1'b1;
        if (bus.DMA_REQ) begin
          dma_serve = 1'b1;
          if (bus.DMA_LAST || (beat_cnt_q == BEAT_TOP)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        // A starved DMA (wait_cnt saturated) beats the CPU for one arbitration.
        if (bus.CPU_REQ && !(bus.DMA_REQ && (wait_cnt_q == WAIT_TOP))) begin
          cpu_serve = 1'b1;
          state_d   = CPU_OWN;
        end else if (bus.DMA_REQ) begin
          state_d = DMA_OWN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if ((state_d == DMA_OWN) && (state_q != DMA_OWN)) begin
      wait_cnt_d = '0;
    end else if (bus.DMA_REQ && (state_d != DMA_OWN) && (wait_cnt_q != WAIT_TOP)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Reset forces the RAM port quiet immediately, even mid-cycle.
  assign cpu_sel        = cpu_serve & RESET_N;
  assign dma_sel        = dma_serve & RESET_N;
  assign bus.DMA_GNT    = dma_gnt & RESET_N;
  assign bus.CPU_STALL  = bus.CPU_REQ & ~cpu_sel;
  assign bus.CPU_RVALID = cpu_rvalid_q;
  assign bus.DMA_RVALID = dma_rvalid_q;
  assign bus.OWNER      = state_q;

  mem_arb_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .cpu_sel  (cpu_sel),
    .cpu_we   (bus.CPU_WE),
    .cpu_addr (bus.CPU_ADDR),
    .cpu_wdata(bus.CPU_WDATA),
    .dma_sel  (dma_sel),
    .dma_we   (bus.DMA_WE),
    .dma_addr (bus.DMA_ADDR),
    .dma_wdata(bus.DMA_WDATA),
    .ram_en   (bus.RAM_EN),
    .ram_we   (bus.RAM_WE),
    .ram_addr (bus.RAM_ADDR),
    .ram_wdata(bus.RAM_WDATA)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner-case sequences,
// then randomized traffic against a rule-level reference model.
module tb_mem_arbiter;

  localparam int BURST_MAX = 8;
  localparam int WAIT_MAX  = 4;

  typedef struct packed {
    logic       rst;
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       dreq;
    logic       dwe;
    logic [7:0] daddr;
    logic [7:0] dwd;
    logic       dlast;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       crv;
    logic       gnt;
    logic       drv;
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [1:0] owner;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_mem = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [255:0]      wr_seen;
  logic [255:0][7:0] mem;

  mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_arbiter #(
    .AW(8), .DW(8), .BURST_MAX(BURST_MAX), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_mem) begin
      wr_seen <= '0;
    end else if (bus.RAM_EN && bus.RAM_WE) begin
      wr_seen[bus.RAM_ADDR] <= 1'b1;
      mem[bus.RAM_ADDR]     <= bus.RAM_WDATA;
    end
  end

  function automatic in_t fi(input int rst, input int creq, input int cwe, input int caddr,
                             input int cwd, input int dreq, input int dwe, input int daddr,
                             input int dwd, input int dlast);
    in_t v;
    v.rst = rst[0]; v.creq = creq[0]; v.cwe = cwe[0];
    v.caddr = caddr[7:0]; v.cwd = cwd[7:0];
    v.dreq = dreq[0]; v.dwe = dwe[0];
    v.daddr = daddr[7:0]; v.dwd = dwd[7:0]; v.dlast = dlast[0];
    return v;
  endfunction

  function automatic out_t fo(input int stall, input int crv, input int gnt, input int drv,
                              input int en, input int we, input int addr, input int wd,
                              input int owner);
    out_t v;
    v.stall = stall[0]; v.crv = crv[0]; v.gnt = gnt[0]; v.drv = drv[0];
    v.en = en[0]; v.we = we[0]; v.addr = addr[7:0]; v.wd = wd[7:0];
    v.owner = owner[1:0];
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst_n         = v.rst;
    bus.CPU_REQ   = v.creq;
    bus.CPU_WE    = v.cwe;
    bus.CPU_ADDR  = v.caddr;
    bus.CPU_WDATA = v.cwd;
    bus.DMA_REQ   = v.dreq;
    bus.DMA_WE    = v.dwe;
    bus.DMA_ADDR  = v.daddr;
    bus.DMA_WDATA = v.dwd;
    bus.DMA_LAST  = v.dlast;
  endtask

  task automatic check(input string name, input out_t exp, input out_t msk);
    out_t act;
    act.stall = bus.CPU_STALL;  act.crv = bus.CPU_RVALID;
    act.gnt   = bus.DMA_GNT;    act.drv = bus.DMA_RVALID;
    act.en    = bus.RAM_EN;     act.we  = bus.RAM_WE;
    act.addr  = bus.RAM_ADDR;   act.wd  = bus.RAM_WDATA;
    act.owner = bus.OWNER;
    n_tests++;
    if (((act ^ exp) & msk) != '0) begin
      n_fail++;
      $display("FAIL %s: got stall=%b crv=%b gnt=%b drv=%b en=%b we=%b addr=%h wd=%h own=%0d, expected stall=%b crv=%b gnt=%b drv=%b en=%b we=%b addr=%h wd=%h own=%0d",
               name, act.stall, act.crv, act.gnt, act.drv, act.en, act.we, act.addr, act.wd, act.owner,
               exp.stall, exp.crv, exp.gnt, exp.drv, exp.en, exp.we, exp.addr, exp.wd, exp.owner);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM-side payload is only meaningful while the RAM is enabled (or under reset).
  task automatic apply(input string name, input in_t vi, input out_t vo);
    out_t msk;
    @(negedge clk);
    drive(vi);
    #1;
    msk = '1;
    if (vi.rst && !vo.en) begin
      msk.we = 1'b0; msk.addr = '0; msk.wd = '0;
    end
    check(name, vo, msk);
  endtask

  vec_t tbl [24];

  initial begin
    in_t  vi;
    out_t exp;
    bit   m_dma, m_cpu_last, m_crd, m_drd, cpu_acc, dma_acc;
    int   m_denied, m_beats;

    drive(fi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset, CPU-only traffic
    tbl[0]  = '{fi(0,1,0,'h10,0,0,0,0,0,0),        fo(1,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{fi(1,1,0,'h10,0,0,0,0,0,0),        fo(0,0,0,0,1,0,'h10,0,0)};
    tbl[2]  = '{fi(1,1,0,'h00,0,0,0,0,0,0),        fo(0,1,0,0,1,0,'h00,0,1)};
    tbl[3]  = '{fi(1,1,0,'h01,0,0,0,0,0,0),        fo(0,1,0,0,1,0,'h01,0,1)};
    tbl[4]  = '{fi(1,1,1,'hFE,'h5A,0,0,0,0,0),     fo(0,1,0,0,1,1,'hFE,'h5A,1)};
    tbl[5]  = '{fi(1,0,0,0,0,0,0,0,0,0),           fo(0,0,0,0,0,0,0,0,1)};
    // DMA write burst of four with LAST on the fourth
    tbl[6]  = '{fi(1,0,0,0,0,1,1,'h20,'hA0,0),     fo(0,0,0,0,0,0,0,0,0)};
    tbl[7]  = '{fi(1,0,0,0,0,1,1,'h20,'hA0,0),     fo(0,0,1,0,1,1,'h20,'hA0,2)};
    tbl[8]  = '{fi(1,0,0,0,0,1,1,'h21,'hA1,0),     fo(0,0,1,0,1,1,'h21,'hA1,2)};
    tbl[9]  = '{fi(1,0,0,0,0,1,1,'h22,'hA2,0),     fo(0,0,1,0,1,1,'h22,'hA2,2)};
    tbl[10] = '{fi(1,0,0,0,0,1,1,'h23,'hA3,1),     fo(0,0,1,0,1,1,'h23,'hA3,2)};
    tbl[11] = '{fi(1,0,0,0,0,0,0,0,0,0),           fo(0,0,0,0,0,0,0,0,0)};
    // single-beat DMA read
    tbl[12] = '{fi(1,0,0,0,0,1,0,'h30,0,1),        fo(0,0,0,0,0,0,0,0,0)};
    tbl[13] = '{fi(1,0,0,0,0,1,0,'h30,0,1),        fo(0,0,1,0,1,0,'h30,0,2)};
    tbl[14] = '{fi(1,0,0,0,0,0,0,0,0,0),           fo(0,0,0,1,0,0,0,0,0)};
    // starvation: both request from a fresh reset
    tbl[15] = '{fi(0,0,0,0,0,0,0,0,0,0),           fo(0,0,0,0,0,0,0,0,0)};
    tbl[16] = '{fi(1,1,0,'h40,0,1,1,'h50,'h55,1),  fo(0,0,0,0,1,0,'h40,0,0)};
    tbl[17] = '{fi(1,1,0,'h40,0,1,1,'h50,'h55,1),  fo(0,1,0,0,1,0,'h40,0,1)};
    tbl[18] = '{fi(1,1,0,'h40,0,1,1,'h50,'h55,1),  fo(0,1,0,0,1,0,'h40,0,1)};
    tbl[19] = '{fi(1,1,0,'h40,0,1,1,'h50,'h55,1),  fo(0,1,0,0,1,0,'h40,0,1)};
    tbl[20] = '{fi(1,1,0,'h40,0,1,1,'h50,'h55,1),  fo(1,1,0,0,0,0,0,0,1)};
    tbl[21] = '{fi(1,1,0,'h40,0,1,1,'h50,'h55,1),  fo(1,0,1,0,1,1,'h50,'h55,2)};
    tbl[22] = '{fi(1,1,0,'h40,0,0,0,0,0,0),        fo(0,0,0,0,1,0,'h40,0,0)};
    tbl[23] = '{fi(1,0,0,0,0,0,0,0,0,0),           fo(0,1,0,0,0,0,0,0,1)};

    for (int k = 0; k < 24; k++) apply($sformatf("tbl%0d", k), tbl[k].i, tbl[k].o);

    // burst cap: 12-beat stream with no LAST while the CPU waits
    apply("cap_rst", fi(0,0,0,0,0,0,0,0,0,0), fo(0,0,0,0,0,0,0,0,0));
    apply("cap_req", fi(1,0,0,0,0,1,1,'h80,'hC0,0), fo(0,0,0,0,0,0,0,0,0));
    for (int b = 0; b < BURST_MAX; b++)
      apply($sformatf("cap_beat%0d", b), fi(1,1,0,'h60,0,1,1,'h80+b,'hC0+b,0),
            fo(1,0,1,0,1,1,'h80+b,'hC0+b,2));
    apply("cap_cpu", fi(1,1,0,'h60,0,1,1,'h88,'hC8,0), fo(0,0,0,0,1,0,'h60,0,0));
    apply("cap_idle", fi(1,0,0,0,0,0,0,0,0,0), fo(0,1,0,0,0,0,0,0,1));

    // reset in the middle of a four-beat burst
    clr_mem = 1'b1;
    apply("mid_rst0", fi(0,0,0,0,0,0,0,0,0,0), fo(0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1 clr_mem = 1'b0;
    apply("mid_req", fi(1,0,0,0,0,1,1,'h90,'hB0,0), fo(0,0,0,0,0,0,0,0,0));
    apply("mid_b1", fi(1,1,0,'h70,0,1,1,'h90,'hB0,0), fo(1,0,1,0,1,1,'h90,'hB0,2));
    apply("mid_b2", fi(1,1,0,'h70,0,1,1,'h91,'hB1,0), fo(1,0,1,0,1,1,'h91,'hB1,2));
    apply("mid_b3", fi(1,1,0,'h70,0,1,1,'h92,'hB2,0), fo(1,0,1,0,1,1,'h92,'hB2,2));
    #1 rst_n = 1'b0;
    #1 check("mid_async", fo(1,0,0,0,0,0,0,0,0), '1);
    apply("mid_hold", fi(0,1,0,'h70,0,1,1,'h93,'hB3,1), fo(1,0,0,0,0,0,0,0,0));
    apply("mid_rereq", fi(1,1,0,'h70,0,1,1,'h93,'hB3,1), fo(0,0,0,0,1,0,'h70,0,0));
    apply("mid_idle", fi(1,0,0,0,0,0,0,0,0,0), fo(0,1,0,0,0,0,0,0,1));
    check_val("mid_wr90", {23'd0, wr_seen[8'h90], mem[8'h90]}, {23'd0, 1'b1, 8'hB0});
    check_val("mid_wr91", {23'd0, wr_seen[8'h91], mem[8'h91]}, {23'd0, 1'b1, 8'hB1});
    check_val("mid_nowr92", {31'd0, wr_seen[8'h92]}, 32'd0);
    check_val("mid_nowr93", {31'd0, wr_seen[8'h93]}, 32'd0);

    // randomized traffic against the rule-level model
    m_dma = 0; m_cpu_last = 0; m_crd = 0; m_drd = 0; m_denied = 0; m_beats = 0;
    for (int c = 0; c < 600; c++) begin
      vi.rst   = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      vi.creq  = ($urandom_range(0, 9) < 6);
      vi.cwe   = 1'($urandom_range(0, 1));
      vi.caddr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      vi.cwd   = 8'($urandom);
      vi.dreq  = ($urandom_range(0, 9) < 6);
      vi.dwe   = 1'($urandom_range(0, 1));
      vi.daddr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      vi.dwd   = 8'($urandom);
      vi.dlast = ($urandom_range(0, 5) == 0);

      exp = '0;
      cpu_acc = 0;
      dma_acc = 0;
      if (!vi.rst) begin
        exp.stall = vi.creq;
      end else begin
        exp.crv   = m_crd;
        exp.drv   = m_drd;
        exp.owner = m_dma ? 2'd2 : (m_cpu_last ? 2'd1 : 2'd0);
        if (m_dma) begin
          exp.gnt   = 1'b1;
          exp.stall = vi.creq;
          dma_acc   = vi.dreq;
        end else begin
          cpu_acc   = vi.creq && !(vi.dreq && m_denied == WAIT_MAX);
          exp.stall = vi.creq && !cpu_acc;
        end
        if (cpu_acc) begin
          exp.en = 1'b1; exp.we = vi.cwe; exp.addr = vi.caddr; exp.wd = vi.cwd;
        end else if (dma_acc) begin
          exp.en = 1'b1; exp.we = vi.dwe; exp.addr = vi.daddr; exp.wd = vi.dwd;
        end
      end

      apply($sformatf("rnd%0d", c), vi, exp);

      if (!vi.rst) begin
        m_dma = 0; m_cpu_last = 0; m_crd = 0; m_drd = 0; m_denied = 0; m_beats = 0;
      end else begin
        m_crd = cpu_acc && !vi.cwe;
        m_drd = dma_acc && !vi.dwe;
        if (m_dma) begin
          m_cpu_last = 0;
          if (dma_acc) begin
            m_beats++;
            if (vi.dlast || m_beats == BURST_MAX) begin
              m_dma = 0; m_beats = 0;
            end
          end else begin
            m_dma = 0; m_beats = 0;
          end
          if (vi.dreq && !m_dma) m_denied = (m_denied < WAIT_MAX) ? m_denied + 1 : WAIT_MAX;
        end else begin
          m_cpu_last = cpu_acc;
          if (vi.dreq && !cpu_acc) begin
            m_dma = 1; m_denied = 0;
          end else if (vi.dreq) begin
            m_denied = (m_denied < WAIT_MAX) ? m_denied + 1 : WAIT_MAX;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter that shares the one data memory between two requesters:
  - the CPU control/datapath (instruction fetch, LOAD/STORE, PUSH/POP/JSR/RTS stack accesses);
  - a DMA/program-loader port that moves bursts of bytes.
- The CPU has fixed priority. A starvation counter guarantees DMA progress, and a burst cap bounds how long the CPU can be stalled.
- Sits between the CPU memory-address/data muxes and the RAM macro. It drives CPU_STALL, which the control FSM uses to hold its current state.

Parameters:
- AW, 8, address width (matches the 8-bit IRL/SP/PC address space).
- DW, 8, data width.
- BURST_MAX, 8, maximum DMA beats per grant (≥1).
- WAIT_MAX, 4, number of denied DMA cycles before the DMA wins over the CPU (≥1).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CPU_REQ  in  1  CPU memory access request, valid this cycle.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  AW  CPU address (PC, IRL or SP already selected).
- CPU_WDATA  in  DW  CPU write data (AC or PC already selected).
- CPU_STALL  out  1  CPU request not served this cycle; CPU must hold all inputs.
- CPU_RVALID  out  1  RAM_DOUT holds CPU read data (one cycle after the accepted read).
- DMA_REQ  in  1  DMA beat request.
- DMA_WE  in  1  DMA write enable.
- DMA_ADDR  in  AW  DMA address.
- DMA_WDATA  in  DW  DMA write data.
- DMA_LAST  in  1  final beat of the burst.
- DMA_GNT  out  1  DMA owns the RAM; a beat is accepted when DMA_REQ && DMA_GNT.
- DMA_RVALID  out  1  RAM_DOUT holds DMA read data (one cycle after the accepted read).
- RAM_EN  out  1  RAM access enable.
- RAM_WE  out  1  RAM write enable.
- RAM_ADDR  out  AW  RAM address.
- RAM_WDATA  out  DW  RAM write data.
- OWNER  out  2  debug: 0 = IDLE, 1 = CPU_OWN, 2 = DMA_OWN.

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RESET_N).
- State after reset: IDLE; wait_cnt = 0; beat_cnt = 0; CPU_RVALID = 0; DMA_RVALID = 0.
- While RESET_N is low:
  - RAM_EN = RAM_WE = 0; DMA_GNT = 0;
  - CPU_STALL = CPU_REQ;
  - RAM_ADDR and RAM_WDATA = 0.
- States: IDLE, CPU_OWN, DMA_OWN. CPU_OWN means the CPU was served last cycle; it has no behavioural difference from IDLE except the OWNER value.
- IDLE / CPU_OWN:
  - If CPU_REQ and not (DMA_REQ && wait_cnt == WAIT_MAX): the CPU is served combinationally in the same cycle. RAM_* = CPU_*, CPU_STALL = 0, next state = CPU_OWN.
  - Else if DMA_REQ: next state = DMA_OWN. RAM_EN = 0 this cycle, and CPU_STALL = CPU_REQ.
  - Else: next state = IDLE, RAM_EN = 0.
- DMA_OWN:
  - DMA_GNT = 1; CPU_STALL = CPU_REQ.
  - If DMA_REQ: RAM_* = DMA_*, beat accepted, beat_cnt increments.
  - Release to IDLE when an accepted beat has DMA_LAST = 1, or is beat number BURST_MAX.
  - Also release to IDLE if DMA_REQ is low; RAM_EN = 0 that cycle.
  - On release, beat_cnt is cleared.
- wait_cnt:
  - Increments (saturating at WAIT_MAX) on each cycle DMA_REQ = 1 and the next state is not DMA_OWN.
  - Cleared on entry to DMA_OWN.
- Grant latency: the DMA sees its first beat one cycle after winning arbitration.
- After a release with both requests pending, the CPU is served first. A new starvation count then starts.
- RVALID timing:
  - CPU_RVALID is registered: 1 in the cycle after an accepted CPU read.
  - DMA_RVALID behaves the same for DMA reads.
  - Writes never produce RVALID.
- Reset mid-burst: the burst is aborted with no partial write after reset, and the DMA must re-request.
- Addresses pass through unmodified. 0xFF is legal, with no wrap logic.

Decomposition:
- Package mem_arb_pkg: owner_t enum (IDLE = 2'd0, CPU_OWN = 2'd1, DMA_OWN = 2'd2), default AW/DW constants.
- Natural sub-module: mem_arb_mux, a purely combinational RAM_* selector driven by owner/serve signals. The FSM and counters stay in mem_arbiter.

Test Plan:
- Reset: RESET_N = 0 with CPU_REQ = 1 → RAM_EN = 0, CPU_STALL = 1, DMA_GNT = 0, OWNER = 0. Release reset → CPU read at addr 0x10 served the same cycle; CPU_RVALID = 1 the next cycle.
- CPU-only: back-to-back fetch of 0x00, 0x01, then write 0x5A to 0xFE → CPU_STALL always 0; RAM write seen with RAM_WE = 1 and address 0xFE.
- DMA burst: idle CPU; DMA writes 0x20..0x23 with DMA_LAST on the 4th beat → DMA_GNT rises one cycle after DMA_REQ, 4 writes, OWNER returns to 0.
- Starvation: CPU_REQ held high, DMA_REQ high (WAIT_MAX = 4) → CPU served 4 cycles, 1 gap cycle with CPU_STALL = 1, then DMA_OWN. CPU_STALL stays 1 until the DMA releases.
- Burst cap: DMA streams 12 beats without DMA_LAST while the CPU requests (BURST_MAX = 8) → release after 8 beats; next cycle the CPU is served.
- Reset mid-burst: assert RESET_N = 0 after beat 2 of 4 → RAM_EN falls immediately; beats 3-4 never written; state IDLE.
